// File: rtl/pram_queue.sv
// pram_queue: 16-deep synchronous FIFO between the PRAM store port and the
// pixel/raycast consumer. The CPU polls `full`, and words drain in order over
// a valid/ready handshake. Every output comes straight from a register.
// Optional build macro PRAM_QUEUE_OVF_EN adds the sticky `overflow` flag and
// the saturating `drop_count` counter for pushes that arrive while full.
module pram_queue #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] PRAM_In,
   input  logic              PRAM_Wr_En,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic [DATA_W-1:0] Out_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready
`ifdef PRAM_QUEUE_OVF_EN
   ,
   output logic              overflow,
   output logic [15:0]       drop_count
`endif
);

   localparam int unsigned   DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_wr_ptr_nxt;
   logic [ADDR_W-1:0] w_rd_ptr_nxt;
   logic [ADDR_W:0]   w_count_nxt;
   logic [DATA_W-1:0] w_head_nxt;

   // Handshake qualification, next pointers/count and the next head word.
   // A word written this edge at the slot the head is about to occupy is
   // bypassed from PRAM_In, because the array does not hold it yet.
   always_comb begin
      w_push       = PRAM_Wr_En & ~r_full;
      w_pop        = r_valid & Out_Ready;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      w_head_nxt   = '0;
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
      if (w_push && !w_pop)      w_count_nxt = r_count + (ADDR_W+1)'(1);
      else if (!w_push && w_pop) w_count_nxt = r_count - (ADDR_W+1)'(1);
      if (w_count_nxt != '0) begin
         if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = PRAM_In;
         else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
   end

   // Storage array write; contents are intentionally left uninitialised.
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= PRAM_In;
   end

   // Pointers, occupancy, status flags and registered head word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_valid  <= 1'b0;
         r_data   <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == C_DEPTH);
         r_empty  <= (w_count_nxt == '0);
         r_valid  <= (w_count_nxt != '0);
         r_data   <= w_head_nxt;
      end
   end

   assign full      = r_full;
   assign empty     = r_empty;
   assign count     = r_count;
   assign Out_Data  = r_data;
   assign Out_Valid = r_valid;

`ifdef PRAM_QUEUE_OVF_EN
   logic        r_overflow;
   logic [15:0] r_drop_count;
   logic        w_drop;

   // A push is dropped whenever the CPU writes while the queue reports full.
   always_comb begin
      w_drop = PRAM_Wr_En & r_full;
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_pram_queue.sv
// Self-checking bench for pram_queue against a queue-based reference model.
// Build with PRAM_QUEUE_OVF_EN defined to also check overflow/drop_count.
module tb_pram_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] PRAM_In;
   logic        PRAM_Wr_En;
   logic        full;
   logic        empty;
   logic [4:0]  count;
   logic [15:0] Out_Data;
   logic        Out_Valid;
   logic        Out_Ready;
`ifdef PRAM_QUEUE_OVF_EN
   logic        overflow;
   logic [15:0] drop_count;
`endif

   pram_queue dut (
      .clk        (clk),
      .reset      (reset),
      .PRAM_In    (PRAM_In),
      .PRAM_Wr_En (PRAM_Wr_En),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .Out_Data   (Out_Data),
      .Out_Valid  (Out_Valid),
      .Out_Ready  (Out_Ready)
`ifdef PRAM_QUEUE_OVF_EN
      ,
      .overflow   (overflow),
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the queue contents in arrival order.
   logic [15:0] mq[$];
   logic        exp_ovf;
   logic [15:0] exp_drop;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [15:0] exp_head();
      return (mq.size() > 0) ? mq[0] : 16'h0000;
   endfunction

   // Apply one cycle of stimulus, advance the model at the edge, settle 1 ns.
   task automatic drive(input logic wr, input logic [15:0] d, input logic rdy, input logic rst);
      int sz;
      PRAM_Wr_En = wr;
      PRAM_In    = d;
      Out_Ready  = rdy;
      reset      = rst;
      @(posedge clk);
      sz = mq.size();
      if (rst) begin
         mq.delete();
         exp_ovf  = 1'b0;
         exp_drop = 16'h0;
      end else begin
         if (wr && sz == 16) begin
            exp_ovf = 1'b1;
            if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
         end
         if (sz > 0 && rdy) void'(mq.pop_front());
         if (wr && sz < 16) mq.push_back(d);
      end
      #1;
      PRAM_Wr_En = 1'b0;
      Out_Ready  = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      checks += 5;
      if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      if (full !== 1'b0)       begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
      if (count !== 5'd0)      begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      if (Out_Valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", Out_Valid); end
      if (Out_Data !== 16'h0)  begin errors++; $display("FAIL reset_data: got %h expected 0000", Out_Data); end
`ifdef PRAM_QUEUE_OVF_EN
      checks += 2;
      if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      if (drop_count !== 16'h0)  begin errors++; $display("FAIL reset_drop: got %h expected 0000", drop_count); end
`endif
   endtask

   task automatic test_single();
      drive(1'b1, 16'hA5A5, 1'b0, 1'b0);
      checks += 3;
      if (Out_Valid !== 1'b1)    begin errors++; $display("FAIL single_valid: got %b expected 1", Out_Valid); end
      if (Out_Data !== 16'hA5A5) begin errors++; $display("FAIL single_data: got %h expected a5a5", Out_Data); end
      if (count !== 5'd1)        begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      checks += 3;
      if (empty !== 1'b1)        begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
      if (count !== 5'd0)        begin errors++; $display("FAIL single_count0: got %0d expected 0", count); end
      if (Out_Data !== 16'h0)    begin errors++; $display("FAIL single_data0: got %h expected 0000", Out_Data); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
      checks += 3;
      if (full !== 1'b1)      begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
      if (count !== 5'd16)    begin errors++; $display("FAIL fill_count: got %0d expected 16", count); end
      if (empty !== 1'b0)     begin errors++; $display("FAIL fill_empty: got %b expected 0", empty); end
      drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
      checks += 3;
      if (count !== 5'd16)    begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
      if (full !== 1'b1)      begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
      if (Out_Data !== 16'h0) begin errors++; $display("FAIL ovf_head: got %h expected 0000", Out_Data); end
`ifdef PRAM_QUEUE_OVF_EN
      checks += 2;
      if (overflow !== 1'b1)     begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      if (drop_count !== 16'd1)  begin errors++; $display("FAIL ovf_drop: got %0d expected 1", drop_count); end
`endif
      // Drain: each word leaving must be 0..15 in order, never DEAD.
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (Out_Data !== 16'(i) || Out_Valid !== 1'b1)
            begin errors++; $display("FAIL drain_word%0d: got %h/v%b expected %h/v1", i, Out_Data, Out_Valid, 16'(i)); end
         drive(1'b0, 16'h0, 1'b1, 1'b0);
      end
      checks += 2;
      if (empty !== 1'b1)  begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
      if (count !== 5'd0)  begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_wrap();
      logic [15:0] d;
      for (int i = 0; i < 10; i++) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (Out_Data !== exp_head()) begin errors++; $display("FAIL wrap_pop%0d: got %h expected %h", i, Out_Data, exp_head()); end
         drive(1'b0, 16'h0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 12; i++) begin
         d = 16'($urandom);
         drive(1'b1, d, 1'b1, 1'b0);
         checks += 2;
         if (Out_Data !== d)  begin errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, Out_Data, d); end
         if (count > 5'd1)    begin errors++; $display("FAIL wrap_count%0d: got %0d expected <=1", i, count); end
      end
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (Out_Data !== exp_head()) begin errors++; $display("FAIL b2b_out%0d: got %h expected %h", i, Out_Data, exp_head()); end
         drive(1'b1, 16'($urandom), 1'b1, 1'b0);
         checks += 2;
         if (count !== 5'd5) begin errors++; $display("FAIL b2b_count%0d: got %0d expected 5", i, count); end
         if (full !== 1'b0)  begin errors++; $display("FAIL b2b_full%0d: got %b expected 0", i, full); end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      checks++;
      if (count !== 5'd7) begin errors++; $display("FAIL mid_pre_count: got %0d expected 7", count); end
      drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
      checks += 3;
      if (count !== 5'd0)     begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
      if (empty !== 1'b1)     begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
      if (Out_Valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", Out_Valid); end
      drive(1'b1, 16'h1234, 1'b0, 1'b0);
      checks += 2;
      if (Out_Data !== 16'h1234) begin errors++; $display("FAIL mid_head: got %h expected 1234", Out_Data); end
      if (count !== 5'd1)        begin errors++; $display("FAIL mid_count1: got %0d expected 1", count); end
   endtask

   task automatic test_random();
      logic wr, rdy;
      for (int i = 0; i < 400; i++) begin
         // Bias toward pushes in the first half to reach full, pops later.
         wr  = ($urandom_range(0, 99) < ((i < 200) ? 75 : 35));
         rdy = ($urandom_range(0, 99) < ((i < 200) ? 35 : 75));
         drive(wr, 16'($urandom), rdy, 1'b0);
         checks += 5;
         if (count !== 5'(mq.size()))           begin errors++; $display("FAIL rnd_count%0d: got %0d expected %0d", i, count, mq.size()); end
         if (full !== (mq.size() == 16))        begin errors++; $display("FAIL rnd_full%0d: got %b expected %b", i, full, mq.size() == 16); end
         if (empty !== (mq.size() == 0))        begin errors++; $display("FAIL rnd_empty%0d: got %b expected %b", i, empty, mq.size() == 0); end
         if (Out_Valid !== (mq.size() != 0))    begin errors++; $display("FAIL rnd_valid%0d: got %b expected %b", i, Out_Valid, mq.size() != 0); end
         if (Out_Data !== exp_head())           begin errors++; $display("FAIL rnd_data%0d: got %h expected %h", i, Out_Data, exp_head()); end
`ifdef PRAM_QUEUE_OVF_EN
         checks += 2;
         if (overflow !== exp_ovf)    begin errors++; $display("FAIL rnd_ovf%0d: got %b expected %b", i, overflow, exp_ovf); end
         if (drop_count !== exp_drop) begin errors++; $display("FAIL rnd_drop%0d: got %0d expected %0d", i, drop_count, exp_drop); end
`endif
      end
   endtask

   initial begin
      reset      = 1'b1;
      PRAM_In    = 16'h0;
      PRAM_Wr_En = 1'b0;
      Out_Ready  = 1'b0;
      exp_ovf    = 1'b0;
      exp_drop   = 16'h0;
      @(negedge clk);
      test_reset();
      test_single();
      test_fill_overflow();
      test_reset();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pram_queue.md
Name: pram_queue

Overview:
- Synchronous FIFO between the memory controller's PRAM port and the pixel/raycast consumer.
- Captures every 16-bit word the CPU stores to the PRAM address.
- Drives the `full` flag that the CPU polls by reading the PRAM address.
- Drains words in order to the downstream consumer over a valid/ready handshake.

Parameters:
- DATA_W, 16, width of each queued word (matches PRAM_Out).
- ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W = 16 entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PRAM_In  input  DATA_W  write data, from the controller's PRAM_Out.
- PRAM_Wr_En  input  1  push request, from the controller's PRAM_Wr_En; one push per cycle while high.
- full  output  1  queue holds DEPTH words; to the controller's `full` input.
- empty  output  1  queue holds 0 words.
- count  output  ADDR_W+1  number of words held, 0..DEPTH.
- Out_Data  output  DATA_W  head-of-queue word.
- Out_Valid  output  1  Out_Data holds a valid word; equals !empty.
- Out_Ready  input  1  consumer accepts the head word this cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled only on clk rising edge.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1, Out_Valid=0, Out_Data=0. Storage array is not cleared.
- Reset mid-operation: all queued words are discarded at that edge. A push or pop in the reset cycle is ignored.
- Storage: DEPTH x DATA_W array; wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH with no special case.
- push = PRAM_Wr_En & !full. On push, mem[wr_ptr] <= PRAM_In and wr_ptr increments.
- pop = Out_Valid & Out_Ready. On pop, rd_ptr increments.
- count update per edge:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- full = (count == DEPTH); empty = (count == 0). Both are registered, derived from the next-state count, so they change on the same edge as count.
- Out_Data = mem[rd_ptr] while Out_Valid; forced to 0 while empty.
- Latency: a word pushed at edge N is visible on Out_Data/Out_Valid after edge N. No same-cycle fall-through.
- Push while full: the word is dropped and all state is unchanged. This holds even if a pop occurs in the same cycle, because the CPU has already sampled full=1.
- Pop while empty: Out_Valid=0, so no pop occurs and no state changes.
- Simultaneous push and pop with 0 < count < DEPTH: both happen; count is unchanged; ordering is preserved.
- Out_Ready held high continuously drains one word per cycle.
- Ordering: strict FIFO. Words leave in exactly the order they were accepted.

Optional Feature:
- Macro: PRAM_QUEUE_OVF_EN.
- When defined, adds output `overflow` (1 bit) and output `drop_count` (16 bits).
  - `overflow` goes to 1 on the edge after any cycle with PRAM_Wr_En & full, and stays set until reset.
  - `drop_count` increments once per dropped push and saturates at 16'hFFFF.
  - Both reset to 0.
- When undefined, neither port exists and dropped pushes leave no trace.
- Core FIFO behaviour is identical in both builds.

Test Plan:
- Reset then idle: assert reset 2 cycles, release → empty=1, full=0, count=0, Out_Valid=0, Out_Data=0.
- Single word: push 16'hA5A5 with Out_Ready=0 → next cycle Out_Valid=1, Out_Data=16'hA5A5, count=1. Then Out_Ready=1 for one cycle → empty=1, count=0.
- Fill and overflow: push 16 words 16'h0000..16'h000F with no pops → full=1, count=16. Push 16'hDEAD → no state change (with PRAM_QUEUE_OVF_EN: overflow=1, drop_count=1). Drain all 16 → 16'h0000..16'h000F in order, no 16'hDEAD.
- Wrap-around: push 10, pop 10, then push 12 with Out_Ready=1 held → pointers wrap past 15. Out_Data sequence matches input exactly, and count never exceeds 1.
- Simultaneous push/pop at count=5: PRAM_Wr_En=1 and Out_Ready=1 for 20 cycles → count stays 5, output sequence in order, full never asserts.
- Reset mid-stream: with count=7, assert reset in a cycle where PRAM_Wr_En=1 and Out_Ready=1 → after the edge count=0, empty=1, Out_Valid=0. The next push of 16'h1234 appears as the head.
